// File: rtl/regfile_pkg.sv
// Shared defaults and sequencer state encoding for the register file.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef logic [0:0] state_t;
    localparam state_t IDLE  = 1'b0;
    localparam state_t CLEAR = 1'b1;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-bit vector: tracks registers with an outstanding producer.
// Lookups are combinational; updates land on the clock edge; no backpressure.
// While wipe_en is high, set/clear are ignored and one entry per cycle is zeroed.
import regfile_pkg::*;

module regfile_scoreboard #(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic              wipe_en,
    input  logic [ADDR_W-1:0] wipe_addr,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    output logic              busy_a,
    output logic              busy_b
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] pending;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else if (wipe_en) begin
            pending[wipe_addr] <= 1'b0;
        end else begin
            if (clr_en)
                pending[clr_addr] <= 1'b0;
            // Set is issued after clear so a same-address set (newer producer) wins.
            if (set_en && !(ZERO_REG != 0 && set_addr == '0))
                pending[set_addr] <= 1'b1;
        end
    end

    assign busy_a = pending[addr_a];
    assign busy_b = pending[addr_b];

endmodule

// File: rtl/reg_file_param.sv
// 2R/1W register file with pending-bit scoreboard and a one-entry-per-cycle clear sequencer.
// Reads are zero latency, writes land on the edge; writes/sets are dropped (not queued) while clearing.
// REGFILE_BYPASS_EN: forwards same-cycle write data and pending clear onto matching read ports.
import regfile_pkg::*;

module reg_file_param #(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              sb_set_en,
    input  logic [ADDR_W-1:0] sb_set_addr,
    output logic              sb_busy_a,
    output logic              sb_busy_b,
    input  logic              clr_req,
    output logic              clr_busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

    logic [DATA_W-1:0] mem [DEPTH];
    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              idle;
    logic              wr_ok;
    logic              set_ok;
    logic              pend_a;
    logic              pend_b;

    assign idle     = (state == IDLE);
    assign wr_ok    = wr_en && idle && !reset && !(ZERO_REG != 0 && wr_addr == '0);
    assign set_ok   = sb_set_en && idle;
    assign clr_busy = (state == CLEAR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            clr_cnt <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (state == IDLE) begin
            if (wr_ok)
                mem[wr_addr] <= wr_data;
            if (clr_req) begin
                state   <= CLEAR;
                clr_cnt <= '0;
            end
        end else begin
            mem[clr_cnt] <= '0;
            clr_cnt      <= clr_cnt + 1'b1;   // wraps back to 0 after the last entry
            if (clr_cnt == LAST)
                state <= IDLE;
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .set_en    (set_ok),
        .set_addr  (sb_set_addr),
        .clr_en    (wr_en && idle),
        .clr_addr  (wr_addr),
        .wipe_en   (!idle),
        .wipe_addr (clr_cnt),
        .addr_a    (rd_addr_a),
        .addr_b    (rd_addr_b),
        .busy_a    (pend_a),
        .busy_b    (pend_b)
    );

    always_comb begin
        rd_data_a = mem[rd_addr_a];
        rd_data_b = mem[rd_addr_b];
        sb_busy_a = pend_a;
        sb_busy_b = pend_b;
        if (ZERO_REG != 0 && rd_addr_a == '0) begin
            rd_data_a = '0;
            sb_busy_a = 1'b0;
        end
        if (ZERO_REG != 0 && rd_addr_b == '0) begin
            rd_data_b = '0;
            sb_busy_b = 1'b0;
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && wr_addr == rd_addr_a) begin
            rd_data_a = wr_data;
            sb_busy_a = set_ok && (sb_set_addr == rd_addr_a);
        end
        if (wr_ok && wr_addr == rd_addr_b) begin
            rd_data_b = wr_data;
            sb_busy_b = set_ok && (sb_set_addr == rd_addr_b);
        end
`endif
    end

endmodule
